mydiv_seq: RTL and testbench



---
 rtl/mydiv_seq.sv | 136 +++++++++++++
 tb/tb_mydiv_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mydiv_seq.sv
// mydiv_seq: sequential unsigned restoring divider, 2N/N -> N quotient, N remainder.
// One quotient bit per clock; zero-divisor and overflow resolve in one cycle.
module mydiv_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [N-1:0]   r_pr;
    logic [N-1:0]   r_q;
    logic [N-1:0]   r_div;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_quot;
    logic [N-1:0]   r_rem;
    logic           r_dbz;
    logic           r_ovf;

    logic [N-1:0]   w_hi;
    logic           w_zero;
    logic           w_ovf;
    logic           w_err;
    logic           w_accept;
    logic           w_last;
    logic [N:0]     w_shr;
    logic [N:0]     w_trial;
    logic           w_ge;
    logic [N-1:0]   w_rn;
    logic [N-1:0]   w_qn;

    assign w_hi     = dividend[2*N-1:N];
    assign w_zero   = (divisor == '0);
    assign w_ovf    = !w_zero && (w_hi >= divisor);
    assign w_err    = w_zero || w_ovf;
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_cnt == CW'(1));

    // One restoring step: shift {R,Q} left, try subtracting the divisor.
    always_comb begin
        w_shr   = {r_pr, r_q[N-1]};
        w_trial = w_shr - {1'b0, r_div};
        w_ge    = !w_trial[N];
        w_rn    = w_ge ? w_trial[N-1:0] : w_shr[N-1:0];
        w_qn    = {r_q[N-2:0], w_ge};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = S_IDLE;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_next = w_err ? S_DONE : S_RUN;
                else       w_next = S_IDLE;
            end
            S_RUN:   w_next = w_last ? S_DONE : S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pr   <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_dbz <= w_zero;
            r_ovf <= w_ovf;
            r_div <= divisor;
            if (w_err) begin
                r_quot <= '1;
                r_rem  <= w_hi;
            end else begin
                r_pr  <= w_hi;
                r_q   <= dividend[N-1:0];
                r_cnt <= CW'(N);
            end
        end else if (r_state == S_RUN) begin
            r_pr  <= w_rn;
            r_q   <= w_qn;
            r_cnt <= r_cnt - CW'(1);
            if (w_last) begin
                r_quot <= w_qn;
                r_rem  <= w_rn;
            end
        end
    end

    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_mydiv_seq.sv
// tb_mydiv_seq: scoreboard bench for mydiv_seq (N=4).
// Driver queues expected results; monitor checks them on each done pulse.
module tb_mydiv_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       overflow;

    mydiv_seq #(.N(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        logic       o;
        int         lat;
        int         nbusy;
        int         t0;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    // Monitor: counts busy cycles and scores each done pulse.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, ".quotient"}, int'(quotient), int'(e.q));
                    chk({e.tag, ".remainder"}, int'(remainder), int'(e.r));
                    chk({e.tag, ".div_by_zero"}, int'(div_by_zero), int'(e.z));
                    chk({e.tag, ".overflow"}, int'(overflow), int'(e.o));
                    chk({e.tag, ".latency"}, cyc - e.t0, e.lat);
                    chk({e.tag, ".busy_cycles"}, busy_cnt, e.nbusy);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic issue(input string tag, input logic [7:0] dd,
                         input logic [3:0] dv, input logic [3:0] eq,
                         input logic [3:0] er, input logic ez,
                         input logic eo);
        exp_t e;
        e.q     = eq;
        e.r     = er;
        e.z     = ez;
        e.o     = eo;
        e.lat   = (ez || eo) ? 1 : 5;
        e.nbusy = (ez || eo) ? 0 : 4;
        e.t0    = cyc;
        e.tag   = tag;
        sb.push_back(e);
        start    = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge where done is high.
    task automatic wait_done(input string tag);
        int i;
        for (i = 0; i < 30; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (i == 30) chk({tag, ".timeout"}, 0, 1);
    endtask

    task automatic run(input string tag, input logic [7:0] dd,
                       input logic [3:0] dv, input logic [3:0] eq,
                       input logic [3:0] er, input logic ez,
                       input logic eo);
        issue(tag, dd, dv, eq, er, ez, eo);
        wait_done(tag);
        @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        dividend = 8'd100;
        divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.quotient", int'(quotient), 0);
        chk("reset.remainder", int'(remainder), 0);
        chk("reset.flags", int'({div_by_zero, overflow}), 0);
        rst = 1'b0;
        @(negedge clk);

        run("d100_7", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("hold.quotient", int'(quotient), 14);
        chk("hold.remainder", int'(remainder), 2);
        run("dEF_F", 8'hEF, 4'hF, 4'hF, 4'hE, 1'b0, 1'b0);
        run("ovf_80_3", 8'h80, 4'd3, 4'hF, 4'h8, 1'b0, 1'b1);
        run("dbz_5_0", 8'd5, 4'd0, 4'hF, 4'h0, 1'b1, 1'b0);
        run("zero_0_1", 8'd0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0);
        run("ovf_eq", 8'h70, 4'd7, 4'hF, 4'h7, 1'b0, 1'b1);

        // start pulsed during RUN must be ignored
        issue("ign_run", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0);
        start = 1'b1;
        dividend = 8'd200;
        divisor = 4'd13;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign_run");

        // back-to-back: new start in the DONE cycle
        issue("b2b_a", 8'd57, 4'd9, 4'd6, 4'd3, 1'b0, 1'b0);
        wait_done("b2b_a");
        issue("b2b_b", 8'd143, 4'd11, 4'd13, 4'd0, 1'b0, 1'b0);
        wait_done("b2b_b");
        issue("b2b_c", 8'd9, 4'd0, 4'hF, 4'h0, 1'b1, 1'b0);
        wait_done("b2b_c");
        @(negedge clk);

        // reset in the 2nd RUN cycle aborts without a done pulse
        start = 1'b1;
        dividend = 8'd100;
        divisor = 4'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.quotient", int'(quotient), 0);
        chk("abort.remainder", int'(remainder), 0);
        chk("abort.flags", int'({div_by_zero, overflow}), 0);
        repeat (10) @(negedge clk);
        run("post_abort", 8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0);

        // multiplier round trip: (A*B)/B == A r 0
        for (int a = 0; a < 16; a++)
            for (int b = 1; b < 16; b++)
                run("rt", 8'(a * b), 4'(b), 4'(a), 4'd0, 1'b0, 1'b0);

        // q*d+r with r<d returns (q,r)
        for (int q = 0; q < 16; q += 3)
            for (int d = 1; d < 16; d++)
                for (int r = 0; r < d; r++)
                    run("qdr", 8'(q * d + r), 4'(d), 4'(q), 4'(r),
                        1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
